// File: rtl/default_slave_wr_pkg.sv
// default_slave_wr_pkg: AXI width defaults, FSM state enum and response codes shared by the default slave.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_pkg;
    typedef enum logic [1:0] {IDLE, WDATA, BRESP} ds_state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/default_slave_wr_if.sv
// default_slave_wr_if: DS_* write channels (AW/W/B) between the W-channel router and the default slave.
interface default_slave_wr_if #(
    parameter int IDS_BITS = `AXI_IDS_BITS,
    parameter int LEN_BITS = `AXI_LEN_BITS
);
    logic [IDS_BITS-1:0]        DS_AWID;
    logic [`AXI_ADDR_BITS-1:0]  DS_AWAddr;
    logic [LEN_BITS-1:0]        DS_AWLen;
    logic [`AXI_SIZE_BITS-1:0]  DS_AWSize;
    logic [1:0]                 DS_AWBurst;
    logic                       DS_AWValid;
    logic                       DS_AWReady;
    logic [`AXI_DATA_BITS-1:0]  DS_WData;
    logic [`AXI_STRB_BITS-1:0]  DS_WStrb;
    logic                       DS_WLast;
    logic                       DS_WValid;
    logic                       DS_WReady;
    logic [IDS_BITS-1:0]        DS_BID;
    logic [1:0]                 DS_BResp;
    logic                       DS_BValid;
    logic                       DS_BReady;

    modport master (
        output DS_AWID, DS_AWAddr, DS_AWLen, DS_AWSize, DS_AWBurst, DS_AWValid,
        output DS_WData, DS_WStrb, DS_WLast, DS_WValid, DS_BReady,
        input  DS_AWReady, DS_WReady, DS_BID, DS_BResp, DS_BValid
    );
    modport slave (
        input  DS_AWID, DS_AWAddr, DS_AWLen, DS_AWSize, DS_AWBurst, DS_AWValid,
        input  DS_WData, DS_WStrb, DS_WLast, DS_WValid, DS_BReady,
        output DS_AWReady, DS_WReady, DS_BID, DS_BResp, DS_BValid
    );
endinterface

// File: rtl/default_slave_wr.sv
// default_slave_wr: accepts one AW, drains its W beats, answers DECERR with the captured ID.
// DS_LEN_CHECK_EN: also end the burst after AWLen+1 beats and flag WLast/length disagreement in err_q.
module default_slave_wr
    import axi_pkg::*;
#(
    parameter int AXI_IDS_BITS = `AXI_IDS_BITS,
    parameter int AXI_LEN_BITS = `AXI_LEN_BITS
) (
    input logic               clk,
    input logic               rst,
    default_slave_wr_if.slave ds
);
    ds_state_e               state_q, state_n;
    logic [AXI_IDS_BITS-1:0] id_q;
    logic [AXI_LEN_BITS-1:0] cnt_q;
    logic                    aw_hs, w_hs, b_hs, w_end;

    // Handshakes are qualified by state, so every output depends on registers only.
    assign aw_hs = state_q == IDLE  && ds.DS_AWValid;
    assign w_hs  = state_q == WDATA && ds.DS_WValid;
    assign b_hs  = state_q == BRESP && ds.DS_BReady;

    assign ds.DS_AWReady = state_q == IDLE;
    assign ds.DS_WReady  = state_q == WDATA;
    assign ds.DS_BValid  = state_q == BRESP;
    assign ds.DS_BID     = id_q;
    assign ds.DS_BResp   = state_q == BRESP ? RESP_DECERR : RESP_OKAY;

`ifdef DS_LEN_CHECK_EN
    logic [AXI_LEN_BITS-1:0] len_q;
    logic                    err_q;
    assign w_end = ds.DS_WLast || cnt_q == len_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (aw_hs) len_q <= ds.DS_AWLen;
            if (w_hs && (ds.DS_WLast != (cnt_q == len_q))) err_q <= 1'b1;
        end
    end
`else
    assign w_end = ds.DS_WLast;
`endif

    always_comb begin
        state_n = aw_hs ? WDATA : (w_hs && w_end) ? BRESP : b_hs ? IDLE : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            if (aw_hs) id_q <= ds.DS_AWID;
            if (aw_hs) cnt_q <= '0;
            else if (w_hs) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_default_slave_wr.sv
// tb_default_slave_wr: directed bench with a B-channel scoreboard for default_slave_wr.
module tb_default_slave_wr;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    default_slave_wr_if #(.IDS_BITS(8), .LEN_BITS(4)) bus ();
    default_slave_wr #(.AXI_IDS_BITS(8), .AXI_LEN_BITS(4)) dut (.clk(clk), .rst(rst), .ds(bus));

    int checks = 0;
    int errors = 0;
    int w_cnt  = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every B handshake pops one expected {BID, BResp}.
    always @(negedge clk) begin
        if (!rst && bus.DS_WValid && bus.DS_WReady) w_cnt++;
        if (!rst && bus.DS_BValid && bus.DS_BReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got %0h with empty scoreboard", {bus.DS_BID, bus.DS_BResp});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.DS_BID, bus.DS_BResp} !== e) begin
                    errors++;
                    $display("FAIL b_resp: got %0h expected %0h", {bus.DS_BID, bus.DS_BResp}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [7:0] id, input logic [3:0] len);
        int n = 0;
        bus.DS_AWID = id;
        bus.DS_AWLen = len;
        bus.DS_AWValid = 1'b1;
        while (!bus.DS_AWReady && n < 20) begin step(); n++; end
        if (n == 20) chk("aw_timeout", 0, 1);
        step();
        bus.DS_AWValid = 1'b0;
    endtask

    task automatic wbeat(input logic last);
        int n = 0;
        bus.DS_WValid = 1'b1;
        bus.DS_WLast = last;
        while (!bus.DS_WReady && n < 20) begin step(); n++; end
        if (n == 20) chk("w_timeout", 0, 1);
        step();
        bus.DS_WValid = 1'b0;
        bus.DS_WLast = 1'b0;
    endtask

    task automatic bresp(input logic [7:0] id, input int stall);
        int n = 0;
        exp_q.push_back({id, RESP_DECERR});
        while (!bus.DS_BValid && n < 20) begin step(); n++; end
        if (n == 20) chk("b_timeout", 0, 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_bvalid", bus.DS_BValid, 1);
            chk("stall_bid", bus.DS_BID, id);
            chk("stall_bresp", bus.DS_BResp, 2'b11);
            step();
        end
        bus.DS_BReady = 1'b1;
        step();
        bus.DS_BReady = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, bus.DS_AWReady, 1);
        chk({tag, "_wready"}, bus.DS_WReady, 0);
        chk({tag, "_bvalid"}, bus.DS_BValid, 0);
        chk({tag, "_bid"}, bus.DS_BID, 0);
        chk({tag, "_bresp"}, bus.DS_BResp, 0);
    endtask

    initial begin
        int base;
        bus.DS_AWID = '0; bus.DS_AWAddr = 32'h9000_0000; bus.DS_AWLen = '0;
        bus.DS_AWSize = 3'd2; bus.DS_AWBurst = 2'b01; bus.DS_AWValid = 1'b0;
        bus.DS_WData = 32'hdead_beef; bus.DS_WStrb = 4'hf; bus.DS_WLast = 1'b0;
        bus.DS_WValid = 1'b0; bus.DS_BReady = 1'b0;
        #1 chk_reset_outputs("reset");
        step(); step();
        rst = 1'b0;
        step();

        // single-beat burst, minimum turnaround
        bus.DS_AWID = 8'h15; bus.DS_AWLen = 4'd0; bus.DS_AWValid = 1'b1;
        chk("t1_awready", bus.DS_AWReady, 1);
        step();
        bus.DS_AWValid = 1'b0;
        chk("t1_wready", bus.DS_WReady, 1);
        chk("t1_awready_low", bus.DS_AWReady, 0);
        bus.DS_WValid = 1'b1; bus.DS_WLast = 1'b1;
        step();
        bus.DS_WValid = 1'b0; bus.DS_WLast = 1'b0;
        chk("t1_bvalid", bus.DS_BValid, 1);
        bresp(8'h15, 0);
        chk("t1_awready_after_b", bus.DS_AWReady, 1);

        // 4-beat burst with gapped WValid
        aw(8'h3c, 4'd3);
        base = w_cnt;
        for (int i = 0; i < 7; i++) begin
            bus.DS_WValid = (i % 2 == 0);
            bus.DS_WLast = (i == 6);
            chk("t2_awready_low", bus.DS_AWReady, 0);
            chk("t2_wready", bus.DS_WReady, 1);
            step();
        end
        bus.DS_WValid = 1'b0; bus.DS_WLast = 1'b0;
        chk("t2_beats", w_cnt - base, 4);
        chk("t2_bvalid", bus.DS_BValid, 1);
        bresp(8'h3c, 5);
        bus.DS_AWID = 8'h44; bus.DS_AWLen = 4'd0; bus.DS_AWValid = 1'b1;
        chk("t3_awready_next", bus.DS_AWReady, 1);
        step();
        bus.DS_AWValid = 1'b0;
        wbeat(1'b1);
        bresp(8'h44, 0);

        // W beat presented before its AW stalls until the address is taken
        bus.DS_WValid = 1'b1; bus.DS_WLast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_wready_idle", bus.DS_WReady, 0);
            step();
        end
        bus.DS_AWID = 8'h5a; bus.DS_AWLen = 4'd0; bus.DS_AWValid = 1'b1;
        step();
        bus.DS_AWValid = 1'b0;
        chk("t4_wready", bus.DS_WReady, 1);
        base = w_cnt;
        step();
        bus.DS_WValid = 1'b0; bus.DS_WLast = 1'b0;
        chk("t4_beat", w_cnt - base, 1);
        chk("t4_bvalid", bus.DS_BValid, 1);
        bresp(8'h5a, 0);

        // reset mid-burst abandons it without a response
        aw(8'h77, 4'd3);
        wbeat(1'b0);
        wbeat(1'b0);
        rst = 1'b1;
        #1 chk_reset_outputs("t5_rst");
        step();
        rst = 1'b0;
        step();
        aw(8'h2a, 4'd0);
        wbeat(1'b1);
        bresp(8'h2a, 0);

        // WLast never asserted on a 2-beat burst
        aw(8'h61, 4'd1);
        wbeat(1'b0);
        wbeat(1'b0);
`ifdef DS_LEN_CHECK_EN
        chk("t6_bvalid", bus.DS_BValid, 1);
        chk("t6_err", dut.err_q, 1);
        bresp(8'h61, 0);
`else
        step(); step();
        chk("t6_wready_hold", bus.DS_WReady, 1);
        chk("t6_bvalid_low", bus.DS_BValid, 0);
        wbeat(1'b1);
        bresp(8'h61, 0);
`endif
        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
